// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS data-port store buffer.
// The STBUF_FWD_EN build option is consumed by stbuf_fifo and mips_store_buffer.
package mips_mem_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RDV  = 2'd3
  } sb_state_e;

  // An entry keeps the word address only; the byte offset never takes part in matching.
  localparam int ENTRY_W_DEF = (AW_DEF - 2) + DW_DEF;

  typedef struct packed {
    logic [AW_DEF-3:0] addr;
    logic [DW_DEF-1:0] data;
  } sb_entry_t;

  function automatic int entry_w(input int aw, input int dw);
    return (aw - 2) + dw;
  endfunction

endpackage

// File: rtl/stbuf_fifo.sv
// Circular store FIFO holding {word address, data}, written at tail, drained from head.
// With STBUF_FWD_EN defined it also reports the youngest entry matching a lookup address.
module stbuf_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-3:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  output logic [AW-3:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
`ifdef STBUF_FWD_EN
  ,
  input  logic [AW-3:0]              lookup_addr,
  output logic                       hit,
  output logic [DW-1:0]              hit_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0]   addr_mem [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));

`ifdef STBUF_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last live match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < cnt) && (addr_mem[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/mips_store_buffer.sv
// Store buffer between the single-cycle MIPS data port and a handshaked data memory.
// Define STBUF_FWD_EN for load forwarding and miss bypass; otherwise loads wait for a full drain.
module mips_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ready,
  input  logic [DW-1:0]          mem_rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef STBUF_FWD_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  sb_state_e       state;
  sb_state_e       state_nxt;
  logic            push;
  logic            pop;
  logic            full;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_after;
  logic [AW-3:0]   head_addr;
  logic [DW-1:0]   head_data;
  logic [DW-1:0]   rdata_q;
  logic            ld_hit;
  logic            ld_pend;
  logic            st_stall;

`ifdef STBUF_FWD_EN
  logic            fifo_hit;
  logic [DW-1:0]   hit_data;
`endif

  stbuf_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .push_addr   (cpu_addr[AW-1:2]),
    .push_data   (cpu_wdata),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (cnt),
    .empty       (empty),
    .full        (full)
`ifdef STBUF_FWD_EN
    ,
    .lookup_addr (cpu_addr[AW-1:2]),
    .hit         (fifo_hit),
    .hit_data    (hit_data)
`endif
  );

`ifdef STBUF_FWD_EN
  assign ld_hit    = cpu_re & fifo_hit;
  assign cpu_rdata = (ld_hit && (state != ST_RDV)) ? hit_data : rdata_q;
`else
  assign ld_hit    = 1'b0;
  assign cpu_rdata = rdata_q;
`endif

  assign count = cnt;

  // A load needs memory until its data is presented in RDV.
  assign ld_pend   = cpu_re & ~ld_hit & (state != ST_RDV);
  assign pop       = (state == ST_WR) & mem_ready;
  assign st_stall  = cpu_we & full & ~pop;
  assign stall     = st_stall | ld_pend;
  assign push      = cpu_we & ~stall;
  assign cnt_after = cnt - CW'(pop) + CW'(push);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_RD) && mem_ready) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (ld_pend && (BYPASS || empty)) state_nxt = ST_RD;
        else if (!empty || push)          state_nxt = ST_WR;
      end
      ST_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {head_addr, 2'b00};
        mem_wdata = head_data;
        if (mem_ready) begin
          if (ld_pend && (BYPASS || (cnt_after == '0))) state_nxt = ST_RD;
          else if (cnt_after != '0)                     state_nxt = ST_WR;
          else                                          state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        mem_req  = 1'b1;
        mem_addr = cpu_addr;
        if (mem_ready) state_nxt = ST_RDV;
      end
      ST_RDV: begin
        state_nxt = (!empty || push) ? ST_WR : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_store_buffer.sv
// Scoreboard bench for mips_store_buffer: expected memory beats and load data are queued
// by the stimulus and checked by an independent monitor.
module tb_mips_store_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_we = 1'b0;
  logic          cpu_re = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          empty;
  logic [CW-1:0] count;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_txn_t;

  mem_txn_t      mem_q[$];
  logic [DW-1:0] ld_q[$];
  int            errors = 0;
  int            checks = 0;

  mips_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mem_txn_t t;
    t.we   = we;
    t.addr = addr;
    t.data = data;
    mem_q.push_back(t);
  endtask

  task automatic store(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    exp_mem(1'b1, addr, data);
  endtask

  // Monitor: completed memory beats and retired loads are compared against the queues.
  always @(negedge clk) begin
    mem_txn_t      e;
    logic [DW-1:0] d;
    if (reset && mem_req && mem_ready) begin
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL mem_txn: got we=%0b addr=0x%0h data=0x%0h expected no transaction",
                 mem_we, mem_addr, mem_wdata);
      end else begin
        e = mem_q.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
          errors++;
          $display("FAIL mem_txn: got we=%0b addr=0x%0h data=0x%0h expected we=%0b addr=0x%0h data=0x%0h",
                   mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
        end
      end
    end
    if (reset && cpu_re && !stall) begin
      checks++;
      if (ld_q.size() == 0) begin
        errors++;
        $display("FAIL load_ret: got rdata=0x%0h expected no load retire", cpu_rdata);
      end else begin
        d = ld_q.pop_front();
        if (cpu_rdata !== d) begin
          errors++;
          $display("FAIL load_ret: got rdata=0x%0h expected 0x%0h", cpu_rdata, d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    reset = 1'b1;
    tick();

    // Single store, memory always ready
    mem_ready = 1'b1;
    store(32'h0, 32'h5);
    #1;
    chk("A_stall", stall, 0);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("A_count1", count, 1);
    chk("A_req_first", mem_req, 1);
    chk("A_we_first", mem_we, 1);
    tick();
    chk("A_count0", count, 0);
    chk("A_req_done", mem_req, 0);

    // Reset while a write waits for mem_ready
    mem_ready = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h4;
    cpu_wdata = 32'h11;
    tick();
    cpu_we = 1'b0;
    #1;
    chk("B_req_pending", mem_req, 1);
    tick();
    reset = 1'b0;
    #1;
    chk("B_rst_req", mem_req, 0);
    chk("B_rst_count", count, 0);
    chk("B_rst_empty", empty, 1);
    chk("B_rst_stall", stall, 0);
    tick();
    reset     = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("B_no_write", mem_req, 0);
    chk("B_count", count, 0);

    // Fill to DEPTH, fifth store stalls, then swaps with a drain
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'h10 + 32'(4 * i), 32'hA1 + 32'(i));
      #1;
      chk("C_accept", stall, 0);
      tick();
    end
    store(32'h20, 32'hA5);
    #1;
    chk("C_full_stall", stall, 1);
    chk("C_full_count", count, 4);
    tick();
    chk("C_hold_count", count, 4);
    chk("C_hold_stall", stall, 1);
    mem_ready = 1'b1;
    #1;
    chk("C_swap_stall", stall, 0);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("C_swap_count", count, 4);
    repeat (4) tick();
    chk("C_drain_count", count, 0);
    chk("C_drain_empty", empty, 1);
    tick();

    // Two pending stores to 0x8, then a load of 0x8
    mem_ready = 1'b0;
    store(32'h8, 32'h7);
    tick();
    store(32'h8, 32'h9);
    tick();
    cpu_we   = 1'b0;
    cpu_re   = 1'b1;
    cpu_addr = 32'h8;
    ld_q.push_back(32'h9);
`ifdef STBUF_FWD_EN
    #1;
    chk("D_fwd_stall", stall, 0);
    chk("D_fwd_rdata", cpu_rdata, 32'h9);
    chk("D_fwd_no_read", mem_we, 1);
    tick();
    cpu_re    = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("D_fwd_empty", empty, 1);
`else
    mem_rdata = 32'h9;
    exp_mem(1'b0, 32'h8, 32'h0);
    #1;
    chk("D_stall", stall, 1);
    tick();
    chk("D_stall_hold", stall, 1);
    mem_ready = 1'b1;
    n = 0;
    while (stall && n < 20) begin
      tick();
      n++;
    end
    chk("D_timeout", stall, 0);
    chk("D_empty", empty, 1);
    chk("D_rdata", cpu_rdata, 32'h9);
    tick();
    cpu_re = 1'b0;
`endif
    mem_ready = 1'b0;
    tick();

    // Load miss behind a slow write: write completes first, then the read
    store(32'h10, 32'h33);
    tick();
    cpu_we    = 1'b0;
    cpu_re    = 1'b1;
    cpu_addr  = 32'h40;
    mem_rdata = 32'hAB;
    exp_mem(1'b0, 32'h40, 32'h0);
    ld_q.push_back(32'hAB);
    #1;
    chk("E_stall_w1", stall, 1);
    chk("E_we_w1", mem_we, 1);
    tick();
    chk("E_stall_w2", stall, 1);
    chk("E_we_w2", mem_we, 1);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("E_we_w3", mem_we, 1);
    chk("E_stall_w3", stall, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("E_rd_req", mem_req, 1);
    chk("E_rd_we", mem_we, 0);
    chk("E_rd_addr", mem_addr, 32'h40);
    chk("E_rd_stall", stall, 1);
    tick();
    chk("E_rd_stall2", stall, 1);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("E_rdv_stall", stall, 0);
    chk("E_rdv_rdata", cpu_rdata, 32'hAB);
    tick();
    cpu_re = 1'b0;
    #1;
    chk("E_idle_req", mem_req, 0);
    tick();

    chk("sb_mem_left", mem_q.size(), 0);
    chk("sb_ld_left", ld_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_store_buffer.md
Name: mips_store_buffer

Overview:
- Store buffer between the single-cycle core's data port (memwrite / dataadr / writedata / readdata) and a data memory with a handshake and variable latency.
- Absorbs stores into a small FIFO and drains them in order to memory.
- Serves loads either from buffered stores or from memory.
- Stalls the core when it cannot accept a store or complete a load in the current cycle.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2).
- AW, 32, address width (byte address; word-aligned use of [AW-1:2]).
- DW, 32, data width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_we  input  1  core store request (memwrite).
- cpu_re  input  1  core load request (memtoreg).
- cpu_addr  input  AW  core data address (aluout).
- cpu_wdata  input  DW  store data.
- cpu_rdata  output  DW  load data to core.
- stall  output  1  core must hold PC/regfile this cycle.
- mem_req  output  1  memory transaction valid.
- mem_we  output  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_ready  input  1  memory accepts/completes the transaction this cycle.
- mem_rdata  input  DW  read data, valid when mem_ready and !mem_we.
- empty  output  1  no stores pending.
- count  output  $clog2(DEPTH)+1  number of pending stores.

Behaviour:
- Reset (reset=0, immediate): FIFO pointers and count=0, empty=1, FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, stall=0. Reset mid-transaction discards all entries and abandons the outstanding request; memory must tolerate the dropped mem_req.
- Entries: {addr[AW-1:2], data}. Addresses are compared on [AW-1:2] only; byte offset is ignored.
- Push: cpu_we & !stall pushes at the clock edge.
  - Store accepted if count<DEPTH, or count==DEPTH and a drain write completes this cycle (WR & mem_ready).
  - Otherwise stall=1 and no push.
- cpu_we and cpu_re together are illegal; the bench never drives them.
- FSM states IDLE, WR, RD, RDV:
  - IDLE:
    - Load miss pending → RD.
    - Else if !empty → WR.
    - A store pushed into an empty buffer reaches WR on the next cycle (one-cycle write latency minimum).
  - WR:
    - mem_req=1, mem_we=1, addr/data from FIFO head, held stable until mem_ready.
    - On mem_ready: pop.
    - Next state: RD if a load miss is pending, else WR if count after pop >0, else IDLE.
  - RD:
    - mem_req=1, mem_we=0, mem_addr=cpu_addr.
    - On mem_ready: capture mem_rdata into the cpu_rdata register → RDV.
  - RDV:
    - stall=0; cpu_rdata holds captured data for one cycle; the core retires the load.
    - Next state: WR if !empty, else IDLE.
  - A write in progress is never aborted; loads wait for the current write beat to finish.
- Load hit (any entry address matches): cpu_rdata = data of the youngest matching entry, combinationally; stall=0; no memory access. Hit check covers entries only, not a same-cycle push.
- Load miss: stall=1 from request until the RDV cycle inclusive of RD; stall=0 in RDV.
- Load misses bypass older non-matching stores. This is safe because every matching store is hit-forwarded.
- Pointer wrap: modulo DEPTH. count distinguishes full from empty.

Optional Feature:
- Macro STBUF_FWD_EN.
- Defined: load hit/forward and load-miss bypass as above.
- Undefined:
  - No address comparators.
  - Any load with !empty stalls until the buffer fully drains, then goes through RD/RDV.
  - Loads with empty buffer go straight to RD.
  - Buffering and stall-on-full behaviour is unchanged.

Decomposition:
- Package mips_mem_pkg:
  - FSM state encoding (IDLE, WR, RD, RDV as 2-bit localparams).
  - Entry struct/width constants.
  - Default DEPTH/AW/DW.
- Sub-module stbuf_fifo: circular storage, head/tail/count, push/pop, full/empty, plus a youngest-match search output (generated only under STBUF_FWD_EN).
- The FSM and stall logic stay in mips_store_buffer.

Test Plan:
- Reset mid-WR with mem_ready held 0 → on reset low: mem_req=0, count=0, empty=1, stall=0, and no write is seen afterwards.
- Single store, addr 0x00, data 5, mem_ready=1 always → mem_req/mem_we high for exactly 1 cycle, starting the cycle after the push, with mem_addr=0, mem_wdata=5; count goes 1→0.
- Five back-to-back stores to 0x10..0x20, DEPTH=4, mem_ready=0 → 5th store sees stall=1. Raising mem_ready for one cycle pops 0x10 and accepts 0x20 in the same cycle; count stays 4.
- With STBUF_FWD_EN, stores 0x8←7 then 0x8←9 pending, mem_ready=0, load 0x8 → cpu_rdata=9 same cycle, stall=0, no read request.
- Load miss 0x40 while WR to 0x10 is waiting, memory latency 3 cycles, mem_rdata=0xAB → read issues only after the write's mem_ready. stall stays high until RDV, then cpu_rdata=0xAB for one cycle.
- Without STBUF_FWD_EN, 2 pending stores and load 0x8 → stall holds until empty=1, then RD to 0x8 returns the last stored value.
